spectrum_display_scan: RTL and testbench

SPECTRUM_DISPLAY_SCAN -- requirements
Module: spectrum_display_scan

---
 rtl/spectrum_pkg.sv | 28 ++
 rtl/bar_encode.sv | 26 ++
 rtl/spectrum_display_scan.sv | 170 +++++++++++++++++
 tb/tb_spectrum_display_scan.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// ============================================================================
// Module   : spectrum_pkg
// Brief    : Shared sizes, scan FSM states and level saturation helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spectrum_pkg;

  localparam int NUM_COLS  = 8;
  localparam int MAG_W     = 4;
  localparam int NUM_ROWS  = 8;
  localparam int MAX_LEVEL = 8;
  localparam int COL_W     = 3;
  localparam int PEAK_W    = 4;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  function automatic logic [PEAK_W-1:0] sat_level(input logic [MAG_W-1:0] mag);
    return (mag > MAG_W'(MAX_LEVEL)) ? PEAK_W'(MAX_LEVEL) : PEAK_W'(mag);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bar_encode.sv
// ============================================================================
// Module   : bar_encode
// Brief    : Thermometer bar plus single peak-hold dot for one LED column.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bar_encode
  import spectrum_pkg::*;
(
  input  logic [PEAK_W-1:0]   i_level,
  input  logic [PEAK_W-1:0]   i_peak,
  output logic [NUM_ROWS-1:0] o_rows
);

  always_comb begin
    o_rows = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      if (k < int'(i_level))    o_rows[k] = 1'b1;
      if (int'(i_peak) == k + 1) o_rows[k] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spectrum_display_scan.sv
// ============================================================================
// Module   : spectrum_display_scan
// Brief    : Multiplexed 8x8 LED spectrum display with tear-free frame
//            transfer, saturating bars and decaying peak hold.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spectrum_display_scan
  import spectrum_pkg::*;
#(
  parameter int DWELL_CYCLES = 1024,
  parameter int DECAY_FRAMES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MAG_W-1:0]    mag0,
  input  logic [MAG_W-1:0]    mag1,
  input  logic [MAG_W-1:0]    mag2,
  input  logic [MAG_W-1:0]    mag3,
  input  logic [MAG_W-1:0]    mag4,
  input  logic [MAG_W-1:0]    mag5,
  input  logic [MAG_W-1:0]    mag6,
  input  logic [MAG_W-1:0]    mag7,
  input  logic                mag_valid,
  output logic [COL_W-1:0]    led_select,
  output logic [NUM_ROWS-1:0] led_rows,
  output logic                frame_done
);

  localparam int DW_W = $clog2(DWELL_CYCLES);
  localparam int DC_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  scan_state_t         r_state;
  scan_state_t         w_state_nx;
  logic [COL_W-1:0]    r_col;
  logic [COL_W-1:0]    w_col_nx;
  logic [DW_W-1:0]     r_dwell;
  logic [DW_W-1:0]     w_dwell_nx;
  logic                w_boundary;

  logic [DC_W-1:0]     r_decay;
  logic                r_pend_vld;
  logic [MAG_W-1:0]    r_pend    [NUM_COLS];
  logic [MAG_W-1:0]    r_disp    [NUM_COLS];
  logic [PEAK_W-1:0]   r_peak    [NUM_COLS];
  logic [MAG_W-1:0]    w_mag     [NUM_COLS];
  logic [MAG_W-1:0]    w_disp_nx [NUM_COLS];
  logic [PEAK_W-1:0]   w_peak_nx [NUM_COLS];
  logic [PEAK_W-1:0]   w_lvl_nx  [NUM_COLS];
  logic                w_update;
  logic                w_decay_tick;

  logic [PEAK_W-1:0]   w_sel_level;
  logic [NUM_ROWS-1:0] w_sel_rows;

  logic [COL_W-1:0]    r_led_select;
  logic [NUM_ROWS-1:0] r_led_rows;
  logic                r_frame_done;

  assign w_mag[0] = mag0;
  assign w_mag[1] = mag1;
  assign w_mag[2] = mag2;
  assign w_mag[3] = mag3;
  assign w_mag[4] = mag4;
  assign w_mag[5] = mag5;
  assign w_mag[6] = mag6;
  assign w_mag[7] = mag7;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_col   <= '0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nx;
      r_col   <= w_col_nx;
      r_dwell <= w_dwell_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_dwell_nx = r_dwell;
    w_boundary = 1'b0;
    case (r_state)
      ST_BLANK: begin
        w_state_nx = ST_SHOW;
        w_dwell_nx = '0;
      end
      ST_SHOW: begin
        if (r_dwell == DW_W'(DWELL_CYCLES - 1)) begin
          w_state_nx = ST_BLANK;
          w_col_nx   = r_col + 1'b1;
          w_boundary = (r_col == COL_W'(NUM_COLS - 1));
        end else begin
          w_dwell_nx = r_dwell + 1'b1;
        end
      end
      default: w_state_nx = ST_BLANK;
    endcase
  end

  // A strobe landing on the boundary bypasses the pending buffer entirely.
  assign w_update     = mag_valid | r_pend_vld;
  assign w_decay_tick = (r_decay == DC_W'(DECAY_FRAMES - 1));

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      w_disp_nx[c] = mag_valid ? w_mag[c] : (r_pend_vld ? r_pend[c] : r_disp[c]);
      w_lvl_nx[c]  = sat_level(w_disp_nx[c]);
      w_peak_nx[c] = r_peak[c];
      if (w_update && (w_lvl_nx[c] >= r_peak[c])) w_peak_nx[c] = w_lvl_nx[c];
      if (w_decay_tick && (w_peak_nx[c] > w_lvl_nx[c])) w_peak_nx[c] = w_peak_nx[c] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_decay    <= '0;
      for (int c = 0; c < NUM_COLS; c++) begin
        r_pend[c] <= '0;
        r_disp[c] <= '0;
        r_peak[c] <= '0;
      end
    end else if (w_boundary) begin
      r_pend_vld <= 1'b0;
      r_decay    <= w_decay_tick ? '0 : r_decay + 1'b1;
      for (int c = 0; c < NUM_COLS; c++) begin
        r_disp[c] <= w_disp_nx[c];
        r_peak[c] <= w_peak_nx[c];
      end
    end else if (mag_valid) begin
      r_pend_vld <= 1'b1;
      for (int c = 0; c < NUM_COLS; c++) begin
        r_pend[c] <= w_mag[c];
      end
    end
  end

  // Outputs are registered from the next-state view so they align with the FSM.
  assign w_sel_level = sat_level(r_disp[w_col_nx]);

  bar_encode u_bar_encode (
    .i_level (w_sel_level),
    .i_peak  (r_peak[w_col_nx]),
    .o_rows  (w_sel_rows)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_select <= '0;
      r_led_rows   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_led_select <= w_col_nx;
      r_led_rows   <= (w_state_nx == ST_SHOW) ? w_sel_rows : '0;
      r_frame_done <= w_boundary;
    end
  end

  assign led_select = r_led_select;
  assign led_rows   = r_led_rows;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_spectrum_display_scan.sv
// ============================================================================
// Module   : tb_spectrum_display_scan
// Brief    : Self-checking bench with cycle-indexed reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spectrum_display_scan;

  localparam int DW = 4;
  localparam int DF = 2;
  localparam int P  = 8 * (DW + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mag [8];
  logic       mag_valid = 1'b0;
  logic [2:0] led_select;
  logic [7:0] led_rows;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spectrum_display_scan #(.DWELL_CYCLES(DW), .DECAY_FRAMES(DF)) dut (
    .clk        (clk),
    .rst        (rst),
    .mag0       (mag[0]),
    .mag1       (mag[1]),
    .mag2       (mag[2]),
    .mag3       (mag[3]),
    .mag4       (mag[4]),
    .mag5       (mag[5]),
    .mag6       (mag[6]),
    .mag7       (mag[7]),
    .mag_valid  (mag_valid),
    .led_select (led_select),
    .led_rows   (led_rows),
    .frame_done (frame_done)
  );

  // Reference model: m_t is the index of the current cycle since reset release;
  // column, phase and boundaries follow from plain arithmetic on it.
  int         m_t = 0;
  bit         m_live = 1'b0;
  int         m_disp [8];
  int         m_pbuf [8];
  int         m_peak [8];
  bit         m_pend;
  int         m_dcnt;
  int         m_col, m_ph, m_lvl;
  bit         m_upd, m_tick;
  logic [2:0] e_sel = '0;
  logic [7:0] e_rows = '0;
  logic       e_fd = 1'b0;

  function automatic int lvl_of(input int m);
    return (m > 8) ? 8 : m;
  endfunction

  function automatic logic [7:0] bar(input int lvl, input int pk);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (k < lvl || k == pk - 1) r[k] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_live = 1'b1; m_pend = 1'b0; m_dcnt = 0;
      for (int c = 0; c < 8; c++) begin m_disp[c] = 0; m_pbuf[c] = 0; m_peak[c] = 0; end
    end else begin
      if (m_t % P == P - 1) begin
        m_upd = mag_valid || m_pend;
        for (int c = 0; c < 8; c++) begin
          if (mag_valid) m_disp[c] = int'(mag[c]);
          else if (m_pend) m_disp[c] = m_pbuf[c];
        end
        m_pend = 1'b0;
        m_tick = (m_dcnt == DF - 1);
        m_dcnt = m_tick ? 0 : m_dcnt + 1;
        for (int c = 0; c < 8; c++) begin
          m_lvl = lvl_of(m_disp[c]);
          if (m_upd && m_lvl >= m_peak[c]) m_peak[c] = m_lvl;
          if (m_tick && m_peak[c] > m_lvl) m_peak[c] = m_peak[c] - 1;
        end
      end else if (mag_valid) begin
        for (int c = 0; c < 8; c++) m_pbuf[c] = int'(mag[c]);
        m_pend = 1'b1;
      end
      m_t = m_t + 1;
    end
    m_col  = (m_t % P) / (DW + 1);
    m_ph   = m_t % (DW + 1);
    e_sel  = 3'(m_col);
    e_rows = (m_ph == 0) ? 8'h00 : bar(lvl_of(m_disp[m_col]), m_peak[m_col]);
    e_fd   = (m_t > 0) && (m_t % P == 0);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, m_t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_select", 8'(led_select), 8'(e_sel));
      chk("model_rows", led_rows, e_rows);
      chk("model_frame_done", 8'(frame_done), 8'(e_fd));
    end
  end

  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (m_t != target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (m_t != target) begin
      checks++; errors++;
      $display("FAIL wait_timeout: reached t=%0d, required t=%0d", m_t, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mag_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] v);
    for (int k = 0; k < 8; k++) mag[k] = v[4*k +: 4];
    mag_valid = 1'b1;
    @(negedge clk);
    mag_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] mags;   // nibble k = mag k
    logic [63:0] rows;   // byte k = column k
  } vec_t;

  vec_t vt [3];

  initial begin : main
    int p;
    for (int k = 0; k < 8; k++) mag[k] = 4'h0;
    vt[0].mags = 32'h24F98310; vt[0].rows = 64'h030FFFFFFF070100;
    vt[1].mags = 32'h89ABCDEF; vt[1].rows = 64'hFFFFFFFFFFFFFFFF;
    vt[2].mags = 32'h01234567; vt[2].rows = 64'h000103070F1F3F7F;

    @(negedge clk);
    chk("reset_rows", led_rows, 8'h00);
    chk("reset_select", 8'(led_select), 8'h00);
    chk("reset_frame_done", 8'(frame_done), 8'h00);

    // Table of frames: each strobed mid-scan, checked on the following scan.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      wait_t(10);
      strobe(vt[v].mags);
      wait_t(36);
      chk("tbl_before_boundary", led_rows, 8'h00);
      for (int c = 0; c < 8; c++) begin
        wait_t(P + c * (DW + 1));
        chk("tbl_blank", led_rows, 8'h00);
        chk("tbl_select", 8'(led_select), 8'(c));
        wait_t(P + c * (DW + 1) + 2);
        chk("tbl_show", led_rows, vt[v].rows[8*c +: 8]);
      end
    end

    // Latest pending frame wins; the first one never reaches the display.
    do_reset();
    wait_t(5);  strobe(32'h55555555);
    wait_t(20); strobe(32'h22222222);
    for (int t = P; t < 2 * P; t++) begin
      wait_t(t);
      chk("latest_wins", led_rows, (t % (DW + 1) == 0) ? 8'h00 : 8'h03);
    end

    // Peak dot decays one row every DF scans after the bars drop to zero.
    do_reset();
    wait_t(5);  strobe(32'h88888888);
    wait_t(85); strobe(32'h00000000);
    for (int k = 0; k <= 16; k++) begin
      wait_t(3 * P + k * P + 3 * (DW + 1) + 2);
      p = 8 - (k + 1) / 2;
      chk("peak_decay", led_rows, (p > 0) ? 8'(1 << (p - 1)) : 8'h00);
    end

    // Strobe exactly on the boundary cycle goes straight to column 0.
    do_reset();
    wait_t(P - 1); strobe(32'h66666666);
    chk("boundary_frame_done", 8'(frame_done), 8'h01);
    chk("boundary_blank", led_rows, 8'h00);
    wait_t(P + 2);
    chk("boundary_show", led_rows, 8'h3F);

    // Reset in column 4 SHOW aborts the scan; strobes during reset are ignored.
    do_reset();
    wait_t(45); strobe(32'hFFFFFFFF);
    wait_t(2 * P + 4 * (DW + 1) + 2);
    chk("abort_pre_rows", led_rows, 8'hFF);
    rst = 1'b1; mag_valid = 1'b1;
    for (int k = 0; k < 8; k++) mag[k] = 4'hF;
    @(negedge clk);
    chk("abort_rows", led_rows, 8'h00);
    chk("abort_select", 8'(led_select), 8'h00);
    chk("abort_frame_done", 8'(frame_done), 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0; mag_valid = 1'b0;
    wait_t(2);
    chk("restart_select", 8'(led_select), 8'h00);
    chk("restart_rows", led_rows, 8'h00);
    wait_t(P - 3);
    chk("restart_blank_data", led_rows, 8'h00);

    // Random frames, strobe timing and occasional resets against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 8; k++) mag[k] = 4'($urandom_range(0, 15));
      mag_valid = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    rst = 1'b0; mag_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
